// File: rtl/fetch_if.sv
// Fetch-side bus bundle: the instruction-memory read port and the decode handshake.
// The controller takes the master view; memory and decode take the slave view.
interface fetch_if #(
    parameter int ADDR_W  = 72,
    parameter int INSTR_W = 72
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_instr, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_instr, out_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one-cycle-latency memory reads,
// buffers responses in a 2-entry queue for decode, and handles redirect and halt.
module fetch_controller #(
    parameter int                ADDR_W   = 72,
    parameter int                INSTR_W  = 72,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    fetch_if.master           bus,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [INSTR_W-1:0] fifo_instr [2];
    logic [ADDR_W-1:0]  fifo_pc    [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic [CNT_W-1:0]   fetch_count_q;
    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         credit_use;

    assign bus.out_valid = (count != 2'd0) & ~redirect_valid;
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.out_pc    = fifo_pc[rd_ptr];
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = inflight & ~redirect_valid;

    // Slots that will be occupied once the in-flight response lands, net of this cycle's pop.
    assign credit_use = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = reset & (state == RUN) & ~redirect_valid & ~halt_req
                        & (credit_use < 3'd2);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign wr_ptr        = rd_ptr ^ count[0];
    assign halted        = (state == HALTED);
    assign fetch_count   = fetch_count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt = state;
        unique case (state)
            RUN:     if (halt_req) state_nxt = HALTING;
            HALTING: if (!inflight) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
        if (redirect_valid) state_nxt = RUN;
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                inflight <= 1'b0;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    inflight_pc <= pc;
                    pc          <= pc + ADDR_W'(1);
                end
                count <= count + {1'b0, push} - {1'b0, pop};
                if (pop) begin
                    rd_ptr        <= ~rd_ptr;
                    fetch_count_q <= fetch_count_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: queue storage has no reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_instr;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a queue-based reference model,
// plus directed scenarios for start-up, backpressure, redirect, halt, wrap and reset.
module tb_fetch_controller;
    localparam int AW = 72;
    localparam int IW = 72;
    localparam int CW = 32;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    typedef enum {M_RUN, M_HALTING, M_HALTED} mstate_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt_req = 1'b0;
    logic          halted;
    logic [CW-1:0] fetch_count;

    fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    fetch_controller #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    mstate_t       m_st;
    logic [AW-1:0] m_pc;
    bit            m_inf;
    logic [AW-1:0] m_inf_pc;
    entry_t        m_q[$];
    logic [CW-1:0] m_cnt;

    // Observation logs for the directed scenarios
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] pop_log[$];
    bit            prev_req;
    logic [AW-1:0] prev_addr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[35:0], a[71:36]} ^ 72'hA5_0F0F_1234_5678_9ABC;
    endfunction

    task automatic model_reset();
        m_st  = M_RUN;
        m_pc  = '0;
        m_inf = 1'b0;
        m_inf_pc = '0;
        m_q.delete();
        m_cnt = '0;
        prev_req = 1'b0;
        prev_addr = '0;
        addr_log.delete();
        pop_log.delete();
    endtask

    // Called at a falling edge; asserts reset asynchronously across one rising edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_fetch_count", fetch_count, '0);
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model.
    task automatic step(input bit rv, input logic [AW-1:0] rpc, input bit hr, input bit rdy);
        logic [95:0] r;
        bit          exp_ov, exp_pop, exp_req;
        int          occ;
        r = {$urandom, $urandom, $urandom};
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        bus.out_ready  = rdy;
        bus.imem_instr = prev_req ? mem_word(prev_addr) : r[71:0];
        #1;
        occ     = m_q.size();
        exp_ov  = (occ != 0) && !rv;
        exp_pop = exp_ov && rdy;
        exp_req = (m_st == M_RUN) && !rv && !hr && (occ + int'(m_inf) - int'(exp_pop) < 2);

        check("imem_req", bus.imem_req, exp_req);
        if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
        check("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            check("out_pc", bus.out_pc, m_q[0].pc);
            check("out_instr", bus.out_instr, m_q[0].instr);
        end
        check("halted", halted, m_st == M_HALTED);
        check("fetch_count", fetch_count, m_cnt);

        if (bus.imem_req) addr_log.push_back(bus.imem_addr);
        if (bus.out_valid && rdy) pop_log.push_back(bus.out_pc);
        prev_req  = bus.imem_req;
        prev_addr = bus.imem_addr;

        if (rv) begin
            m_pc  = rpc;
            m_q.delete();
            m_inf = 1'b0;
            m_st  = M_RUN;
        end else begin
            if (exp_pop) begin
                void'(m_q.pop_front());
                m_cnt++;
            end
            if (m_inf) begin
                check("push_room", m_q.size() < 2, 1'b1);
                m_q.push_back(entry_t'{mem_word(m_inf_pc), m_inf_pc});
            end
            if (m_st == M_RUN && hr) m_st = M_HALTING;
            else if (m_st == M_HALTING && !m_inf) m_st = M_HALTED;
            if (exp_req) begin
                m_inf    = 1'b1;
                m_inf_pc = m_pc;
                m_pc     = m_pc + 1;
            end else begin
                m_inf = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] all1;
        logic [95:0]   r;
        logic [AW-1:0] rpc;
        int            n;
        all1 = '1;
        bus.out_ready = 1'b0;
        bus.imem_instr = '0;
        model_reset();

        // Start-up streaming with decode always ready
        do_reset();
        repeat (10) step(0, '0, 0, 1);
        check("stream_fetch_count", fetch_count, 8);
        check("stream_req_total", addr_log.size(), 10);
        for (int i = 0; i < 10; i++) check("stream_addr", addr_log[i], i);
        check("stream_pop_total", pop_log.size(), 8);
        for (int i = 0; i < 8; i++) check("stream_pop_pc", pop_log[i], i);

        // Backpressure from reset: two requests only, then in-order drain
        do_reset();
        repeat (6) step(0, '0, 0, 0);
        check("bp_req_total", addr_log.size(), 2);
        check("bp_addr0", addr_log[0], 0);
        check("bp_addr1", addr_log[1], 1);
        check("bp_req_off", bus.imem_req, 1'b0);
        repeat (12) step(0, '0, 0, 1);
        check("bp_pop_total", pop_log.size(), 12);
        for (int i = 0; i < 12; i++) check("bp_pop_pc", pop_log[i], i);

        // Redirect with a buffered entry and a fetch in flight
        do_reset();
        repeat (5) step(0, '0, 0, 1);
        step(1, 72'h40, 0, 1);
        addr_log.delete();
        pop_log.delete();
        repeat (6) step(0, '0, 0, 1);
        check("redir_first_addr", addr_log[0], 72'h40);
        check("redir_pop_total", pop_log.size(), 4);
        check("redir_pop0", pop_log[0], 72'h40);
        check("redir_pop1", pop_log[1], 72'h41);

        // Halt pulse when the PC reaches 5, then restart by redirect
        do_reset();
        for (int i = 0; i < 20 && m_pc != 5; i++) step(0, '0, 0, 1);
        step(0, '0, 1, 1);
        repeat (8) step(0, '0, 0, 1);
        check("halt_req_total", addr_log.size(), 5);
        check("halt_halted", halted, 1'b1);
        check("halt_pop_total", pop_log.size(), 5);
        check("halt_fetch_count", fetch_count, 5);
        step(1, 72'h100, 0, 1);
        check("halt_cleared", halted, 1'b0);
        addr_log.delete();
        step(0, '0, 0, 1);
        check("restart_req_total", addr_log.size(), 1);
        if (addr_log.size() >= 1) check("restart_addr", addr_log[0], 72'h100);

        // PC wrap at the top of the address space
        step(1, all1, 0, 1);
        addr_log.delete();
        repeat (3) step(0, '0, 0, 1);
        check("wrap_addr_top", addr_log[0], all1);
        check("wrap_addr_zero", addr_log[1], 0);

        // Reset in the middle of a stalled stream with a full buffer
        repeat (5) step(0, '0, 0, 0);
        check("pre_reset_valid", bus.out_valid, 1'b1);
        do_reset();
        repeat (4) step(0, '0, 0, 1);
        check("post_reset_addr", addr_log[0], 0);
        check("post_reset_pop_total", pop_log.size(), 2);
        check("post_reset_pop0", pop_log[0], 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 900 == 0) begin
                do_reset();
            end else begin
                r = {$urandom, $urandom, $urandom};
                rpc = ($urandom % 4 == 0) ? (all1 - AW'($urandom_range(0, 3))) : r[71:0];
                step(($urandom % 16) == 0, rpc, ($urandom % 24) == 0, ($urandom % 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
